// File: rtl/collide_check.sv
// Scans a swept-volume occupancy grid against an obstacle grid one word per cycle,
// reporting a collision flag, the lowest colliding cell and the number of colliding cells.
module collide_check #(
    parameter int GRID_BITS = 8192,
    parameter int WORD_W    = 64,
    parameter int IDX_W     = 13,
    parameter int CNT_W     = 14
) (
    input  logic                 CLK,
    input  logic                 RST_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [GRID_BITS-1:0] edgeState,
    input  logic [GRID_BITS-1:0] obstacleMap,
    output logic                 busy,
    output logic                 done,
    output logic                 collide,
    output logic [IDX_W-1:0]     hitIndex,
    output logic [CNT_W-1:0]     hitCount
);

    localparam int NUM_WORDS = GRID_BITS / WORD_W;
    localparam int BIT_W     = $clog2(WORD_W);
    localparam int WIDX_W    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int POP_W     = $clog2(WORD_W) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state;
    state_t              next_state;
    logic [WIDX_W-1:0]   word_idx;
    logic                last_word;
    logic                clear_res;
    logic                acc_en;

    logic [IDX_W-1:0]    word_base;
    logic [WORD_W-1:0]   edge_word;
    logic [WORD_W-1:0]   obst_word;
    logic [WORD_W-1:0]   match;
    logic [BIT_W-1:0]    bit_pos;
    logic [POP_W-1:0]    pop;

    assign word_base = IDX_W'(word_idx) << BIT_W;
    assign edge_word = edgeState[word_base +: WORD_W];
    assign obst_word = obstacleMap[word_base +: WORD_W];
    assign match     = edge_word & obst_word;
    assign last_word = (word_idx == WIDX_W'(NUM_WORDS - 1));

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // Lowest set bit and population count of the current word's overlap.
    always_comb begin
        bit_pos = '0;
        pop     = '0;
        for (int i = WORD_W - 1; i >= 0; i--) begin
            if (match[i]) begin
                bit_pos = BIT_W'(i);
            end
        end
        for (int i = 0; i < WORD_W; i++) begin
            pop = pop + POP_W'(match[i]);
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        clear_res  = 1'b0;
        acc_en     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = SCAN;
                    clear_res  = 1'b1;
                end
            end
            SCAN: begin
                if (abort) begin
                    next_state = IDLE;
                    clear_res  = 1'b1;
                end else begin
                    acc_en = 1'b1;
                    if (last_word) begin
                        next_state = DONE;
                    end
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Accumulators: the first colliding word fixes hitIndex, every word adds to hitCount.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            word_idx <= '0;
            collide  <= 1'b0;
            hitIndex <= '0;
            hitCount <= '0;
        end else if (clear_res) begin
            word_idx <= '0;
            collide  <= 1'b0;
            hitIndex <= '0;
            hitCount <= '0;
        end else if (acc_en) begin
            word_idx <= last_word ? '0 : word_idx + 1'b1;
            hitCount <= hitCount + CNT_W'(pop);
            if ((match != '0) && !collide) begin
                collide  <= 1'b1;
                hitIndex <= word_base | IDX_W'(bit_pos);
            end
        end
    end

endmodule

// File: doc/collide_check.md
Name: collide_check

Overview:
- Downstream consumer of the swept-volume accumulator's 8192-bit edgeState occupancy grid.
- Once per check, scans the accumulated grid against a static obstacleMap of the same geometry, WORD_W bits per cycle.
- Reports a collision flag, the lowest colliding cell index, and the total number of colliding cells.
- The sequencer uses the result to accept or reject the planned motion, then clears the accumulator for the next candidate.

Parameters:
GRID_BITS  8192  cells in the occupancy grid; must be an integer multiple of WORD_W
WORD_W     64    cells examined per SCAN cycle
IDX_W      13    width of cell index, clog2(GRID_BITS)
CNT_W      14    width of hit count, clog2(GRID_BITS)+1
Derived: NUM_WORDS = GRID_BITS/WORD_W (128 at defaults).

Ports:
CLK          input   1          clock, all state on rising edge
RST_n        input   1          reset, asynchronous, active-low
start        input   1          request a scan; sampled only in IDLE
abort        input   1          cancel a scan in progress; sampled only in SCAN
edgeState    input   GRID_BITS  accumulated swept-volume grid; must be stable while busy=1
obstacleMap  input   GRID_BITS  obstacle grid; must be stable while busy=1
busy         output  1          high in SCAN and DONE
done         output  1          one-cycle pulse, results valid
collide      output  1          at least one cell set in both grids
hitIndex     output  IDX_W      lowest index i with edgeState[i] & obstacleMap[i]; 0 if none
hitCount     output  CNT_W      number of cells set in both grids

Behaviour:
- Reset: RST_n low asynchronously forces the following, held until RST_n rises.
  - state=IDLE, wordIdx=0.
  - busy=0, done=0, collide=0, hitIndex=0, hitCount=0.
- States: IDLE, SCAN, DONE.
  - IDLE: start=1 at edge E0 -> SCAN; wordIdx=0; collide, hitIndex and hitCount cleared to 0; busy=1 after E0.
  - SCAN: each edge processes word k=wordIdx, i.e. bits [k*WORD_W +: WORD_W].
    - m = edgeState word AND obstacleMap word.
    - hitCount += popcount(m).
    - If m!=0 and collide==0: collide<=1, hitIndex <= k*WORD_W + lowest set bit of m.
    - If m!=0 and collide==1: hitIndex unchanged (first hit wins).
    - wordIdx increments each edge; on the edge processing k=NUM_WORDS-1 -> DONE, wordIdx<=0.
  - DONE: done=1 for exactly one cycle; next edge -> IDLE, done=0.
- Timing at defaults:
  - Words 0..127 are processed on edges E1..E128.
  - done is high between E128 and E129.
  - busy is high from after E0 until E129.
  - Check latency is 129 cycles from start sampling to done.
- Results: collide, hitIndex and hitCount hold their values in IDLE until the next accepted start. They are never altered by input changes in IDLE.
- start in SCAN or DONE: ignored, no queuing.
- abort in SCAN: next edge -> IDLE; no done pulse; collide, hitIndex and hitCount cleared to 0. abort in IDLE or DONE is ignored.
- start and abort both high in IDLE: start wins; abort is not sampled in IDLE.
- Arithmetic:
  - hitCount cannot overflow; max GRID_BITS fits in CNT_W.
  - hitIndex = {wordIdx, bitPos}, where bitPos is log2(WORD_W) bits.
  - The per-cycle popcount and priority encode are combinational from the selected word.
  - The only sequential stage is the accumulator registers. No extra pipeline is permitted without changing the latency above.
- Reset mid-scan: everything returns to reset values immediately; no done pulse.
- Inputs changing while busy: results are undefined. The upstream sequencer must hold the accumulator (no OR, no clear) during a check.

Test Plan:
- Disjoint grids: edgeState all 0, obstacleMap all 1, pulse start -> done at cycle 129; collide=0, hitIndex=0, hitCount=0; busy high 129 cycles.
- Single hit: both grids have only bit 5000 set -> collide=1, hitIndex=5000, hitCount=1.
- Multiple hits: overlap bits {8191, 64, 63, 3000} -> hitIndex=63, hitCount=4. Then all 8192 overlapping -> hitIndex=0, hitCount=8192.
- Abort at SCAN cycle 40 with overlap bit 10 -> returns to IDLE; no done pulse; collide=0, hitCount=0. A subsequent start gives a full scan with hitIndex=10.
- start held high continuously -> scans back-to-back, each 130 cycles apart including the DONE and IDLE cycles. start asserted during SCAN does not restart the scan (done is still at cycle 129). Results hold in IDLE while grids change.
- RST_n pulsed low mid-scan (cycle 70), asynchronous to CLK -> all outputs 0 immediately; no done pulse; state is IDLE after release.
